// File: rtl/sid_pkg.sv
// Shared types and constants for the SID combined-waveform table path.
package sid_pkg;

  localparam int unsigned NumVoicesDef = 3;
  localparam int unsigned IdxW         = 12;

  // One table entry, packed as {_st, p_t, ps_, pst} from MSB to LSB.
  typedef struct packed {
    logic [7:0] st;
    logic [7:0] pt;
    logic [7:0] ps;
    logic [7:0] pst;
  } wave_lut_t;

  localparam int unsigned WaveLutW = $bits(wave_lut_t);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture
  } state_e;

endpackage

// File: rtl/sid_lut_sched.sv
// Time-multiplexes one fixed-latency combined-waveform table across all voices: each sample
// strobe snapshots every voice's indices, then issues one lookup slot per voice in order.
module sid_lut_sched
  import sid_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = NumVoicesDef,
  parameter int unsigned LUT_LATENCY = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce_1m,
  input  logic [NUM_VOICES*IdxW-1:0]     acc_ps_in,
  input  logic [NUM_VOICES*IdxW-1:0]     acc_t_in,
  output logic [IdxW-1:0]                lut_acc_ps,
  output logic [IdxW-1:0]                lut_acc_t,
  output logic                           lut_req,
  input  logic [WaveLutW-1:0]            lut_data,
  output logic [NUM_VOICES*WaveLutW-1:0] res_data,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int unsigned VW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CntW = 3;

  localparam logic [VW-1:0]   LastVoice = VW'(NUM_VOICES - 1);
  // Final WAIT count; WAIT is skipped entirely when the table answers in one clock.
  localparam logic [CntW-1:0] WaitLast  = CntW'((LUT_LATENCY > 1) ? (LUT_LATENCY - 2) : 0);

  state_e          state_q, state_d;
  logic [VW-1:0]   v_q, v_d, v_nxt;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] snap_ps_q [NUM_VOICES];
  logic [IdxW-1:0] snap_t_q  [NUM_VOICES];
  logic [IdxW-1:0] acc_ps_q, acc_t_q;
  wave_lut_t       res_q     [NUM_VOICES];
  logic            done_q, overrun_q;

  logic start, capture, last_voice, wait_last;

  assign last_voice = (v_q == LastVoice);
  assign wait_last  = (cnt_q == WaitLast);
  assign v_nxt      = v_q + VW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      v_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ce_1m) begin
          state_d = StIssue;
          v_d     = '0;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = (LUT_LATENCY > 1) ? StWait : StCapture;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (wait_last) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (last_voice) begin
          state_d = StIdle;
          v_d     = '0;
        end else begin
          state_d = StIssue;
          v_d     = v_nxt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    lut_req = 1'b0;
    busy    = 1'b1;
    start   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy  = 1'b0;
        start = ce_1m;
      end
      StIssue:   lut_req = 1'b1;
      StWait:    lut_req = 1'b0;
      StCapture: capture = 1'b1;
      default:   busy    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_ps_q  <= '0;
      acc_t_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        snap_ps_q[k] <= '0;
        snap_t_q[k]  <= '0;
        res_q[k]     <= '0;
      end
    end else begin
      done_q <= capture && last_voice;
      if (ce_1m && busy) begin
        overrun_q <= 1'b1;
      end
      if (start) begin
        for (int k = 0; k < NUM_VOICES; k++) begin
          snap_ps_q[k] <= acc_ps_in[k*IdxW +: IdxW];
          snap_t_q[k]  <= acc_t_in[k*IdxW +: IdxW];
        end
        // Voice 0 bypasses the snapshot so its address is ready in the first ISSUE cycle.
        acc_ps_q <= acc_ps_in[IdxW-1:0];
        acc_t_q  <= acc_t_in[IdxW-1:0];
      end
      if (capture) begin
        res_q[v_q] <= lut_data;
        if (!last_voice) begin
          acc_ps_q <= snap_ps_q[v_nxt];
          acc_t_q  <= snap_t_q[v_nxt];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_res
    assign res_data[k*WaveLutW +: WaveLutW] = res_q[k];
  end

  assign lut_acc_ps = acc_ps_q;
  assign lut_acc_t  = acc_t_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sid_lut_sched.sv
// Checks two scheduler instances (table latency 3 and 1) against a cycle-time reference model.
module tb_sid_lut_sched;

  localparam int NV = 3;
  localparam int L0 = 3;
  localparam int L1 = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       ce;
  logic [NV*12-1:0] acc_ps, acc_t;
  logic [11:0]      lps   [2];
  logic [11:0]      lt    [2];
  logic             lreq  [2];
  logic             busy  [2];
  logic             done  [2];
  logic             ovr   [2];
  logic [31:0]      ldata [2];
  logic [NV*32-1:0] res   [2];

  always #5 clk = ~clk;

  sid_lut_sched #(.NUM_VOICES(NV), .LUT_LATENCY(L0)) u_dut_l3 (
    .clk        (clk),
    .reset      (reset),
    .ce_1m      (ce[0]),
    .acc_ps_in  (acc_ps),
    .acc_t_in   (acc_t),
    .lut_acc_ps (lps[0]),
    .lut_acc_t  (lt[0]),
    .lut_req    (lreq[0]),
    .lut_data   (ldata[0]),
    .res_data   (res[0]),
    .busy       (busy[0]),
    .done       (done[0]),
    .overrun    (ovr[0])
  );

  sid_lut_sched #(.NUM_VOICES(NV), .LUT_LATENCY(L1)) u_dut_l1 (
    .clk        (clk),
    .reset      (reset),
    .ce_1m      (ce[1]),
    .acc_ps_in  (acc_ps),
    .acc_t_in   (acc_t),
    .lut_acc_ps (lps[1]),
    .lut_acc_t  (lt[1]),
    .lut_req    (lreq[1]),
    .lut_data   (ldata[1]),
    .res_data   (res[1]),
    .busy       (busy[1]),
    .done       (done[1]),
    .overrun    (ovr[1])
  );

  function automatic logic [31:0] lut_fn(input logic [11:0] ps, input logic [11:0] t);
    return {ps[7:0], t[7:0], ps[11:4] ^ t[11:4], ps[7:0] + t[7:0]};
  endfunction

  function automatic int lat(input int id);
    return (id == 0) ? L0 : L1;
  endfunction

  // Table models: fixed pipelines of lut_fn(address).
  logic [31:0] pipe3 [3];
  logic [31:0] pipe1;
  always @(posedge clk) begin
    pipe3[0] <= lut_fn(lps[0], lt[0]);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    pipe1    <= lut_fn(lps[1], lt[1]);
  end
  assign ldata[0] = pipe3[2];
  assign ldata[1] = pipe1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model: a sequence is its start cycle plus snapshot; everything else is arithmetic.
  int          st   [2];
  logic [11:0] sps  [2][NV];
  logic [11:0] stt  [2][NV];
  logic [31:0] mres [2][NV];
  bit          movr [2];

  task automatic model_edge(input int id, input int c);
    int sl, len, off;
    bit was_busy;
    sl  = lat(id) + 1;
    len = NV * sl;
    if (reset) begin
      st[id]   = -1;
      movr[id] = 1'b0;
      for (int k = 0; k < NV; k++) mres[id][k] = '0;
      return;
    end
    was_busy = (st[id] >= 0) && (c > st[id]) && (c <= st[id] + len);
    if (was_busy) begin
      off = c - st[id] - 1;
      if (off % sl == lat(id)) mres[id][off/sl] = lut_fn(sps[id][off/sl], stt[id][off/sl]);
    end
    if (ce[id]) begin
      if (was_busy) begin
        movr[id] = 1'b1;
      end else begin
        st[id] = c;
        for (int k = 0; k < NV; k++) begin
          sps[id][k] = acc_ps[k*12 +: 12];
          stt[id][k] = acc_t[k*12 +: 12];
        end
      end
    end
  endtask

  task automatic check_dut(input int id);
    int sl, len, off;
    bit act;
    logic [11:0]      eps, et;
    logic [NV*32-1:0] er;
    string pfx;
    pfx = $sformatf("L%0d_", lat(id));
    sl  = lat(id) + 1;
    len = NV * sl;
    off = cyc - st[id] - 1;
    act = (st[id] >= 0) && (off < len);
    if (st[id] < 0) begin
      eps = '0;
      et  = '0;
    end else if (act) begin
      eps = sps[id][off/sl];
      et  = stt[id][off/sl];
    end else begin
      eps = sps[id][NV-1];
      et  = stt[id][NV-1];
    end
    for (int k = 0; k < NV; k++) er[k*32 +: 32] = mres[id][k];
    check({pfx, "busy"},   busy[id], act);
    check({pfx, "req"},    lreq[id], act && (off % sl == 0));
    check({pfx, "done"},   done[id], (st[id] >= 0) && (off == len));
    check({pfx, "acc_ps"}, lps[id],  eps);
    check({pfx, "acc_t"},  lt[id],   et);
    check({pfx, "ovr"},    ovr[id],  movr[id]);
    check({pfx, "res"},    res[id],  er);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge(0, cyc);
    model_edge(1, cyc);
    cyc++;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic rand_acc();
    for (int k = 0; k < NV; k++) begin
      acc_ps[k*12 +: 12] = 12'($urandom);
      acc_t[k*12 +: 12]  = 12'($urandom);
    end
  endtask

  initial begin
    logic [NV*32-1:0] exp_res;
    st[0] = -1;
    st[1] = -1;
    reset = 1'b1;
    ce    = 2'b00;
    rand_acc();
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_res", res[0], '0);
    check("rst_addr", lps[0], 12'h000);

    // Directed sequence: three voices, overlapping strobe, late input change, back-to-back start.
    acc_ps = {12'h789, 12'h456, 12'h123};
    acc_t  = {12'h0ab, 12'h0cd, 12'h0ef};
    ce     = 2'b11;
    step();
    ce = 2'b00;
    check("t1_req", lreq[0], 1'b1);
    check("t1_addr", lps[0], 12'h123);
    exp_res = {lut_fn(12'h789, 12'h0ab), lut_fn(12'h456, 12'h0cd), lut_fn(12'h123, 12'h0ef)};
    for (int r = 1; r < 14; r++) begin
      rand_acc();
      if (r == 3) acc_t[35:24] = 12'hfff;
      ce[0] = (r == 6);
      ce[1] = (r == 7);
      step();
      case (r + 1)
        5: begin
          check("t5_req", lreq[0], 1'b1);
          check("t5_addr", lps[0], 12'h456);
        end
        7: begin
          check("t7_ovr", ovr[0], 1'b1);
          check("t7_l1_done", done[1], 1'b1);
        end
        8: check("t8_l1_restart", lreq[1], 1'b1);
        9: begin
          check("t9_addr", lps[0], 12'h789);
          check("t9_snap_t", lt[0], 12'h0ab);
        end
        13: begin
          check("t13_done", done[0], 1'b1);
          check("t13_res", res[0], exp_res);
        end
        default: ;
      endcase
    end
    ce = 2'b00;
    repeat (16) begin
      rand_acc();
      step();
    end

    // Reset in the middle of a sequence.
    ce = 2'b11;
    rand_acc();
    step();
    ce = 2'b00;
    for (int r = 1; r <= 7; r++) begin
      rand_acc();
      reset = (r == 7);
      step();
    end
    reset = 1'b0;
    check("mid_rst_busy", busy[0], 1'b0);
    check("mid_rst_res", res[0], '0);
    check("mid_rst_addr", lps[0], 12'h000);
    repeat (10) step();

    // Random strobes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_acc();
      reset = ($urandom_range(0, 79) == 0);
      ce[0] = ($urandom_range(0, 5) == 0);
      ce[1] = ($urandom_range(0, 3) == 0);
      step();
    end
    reset = 1'b0;
    ce    = 2'b00;
    repeat (16) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_lut_sched.md
SID_LUT_SCHED -- requirements
Module: sid_lut_sched

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of voices sharing one combined-waveform table.
REQ-002 SHALL have parameter LUT_LATENCY, default 3, table clocks from address valid to data valid; legal range 1..7.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ce_1m  input  1  sample-period strobe, 1-cycle pulse.
REQ-006 SHALL have port acc_ps_in  input  NUM_VOICES x 12  per-voice pulse/saw table index.
REQ-007 SHALL have port acc_t_in  input  NUM_VOICES x 12  per-voice triangle table index.
REQ-008 SHALL have port lut_acc_ps  output  12  shared table pulse/saw address.
REQ-009 SHALL have port lut_acc_t  output  12  shared table triangle address.
REQ-010 SHALL have port lut_req  output  1  high in first cycle of each lookup slot.
REQ-011 SHALL have port lut_data  input  4 x 8  table result {_st, p_t, ps_, pst}.
REQ-012 SHALL have port res_data  output  NUM_VOICES x 4 x 8  per-voice latched results.
REQ-013 SHALL have port busy  output  1  sequence in progress.
REQ-014 SHALL have port done  output  1  1-cycle pulse, all results updated.
REQ-015 SHALL have port overrun  output  1  sticky: ce_1m arrived while busy.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, CAPTURE; voice index v counts 0..NUM_VOICES-1.
REQ-017 IDLE + ce_1m in cycle T: snapshot all acc_ps_in/acc_t_in, load voice 0 addresses, enter ISSUE; addresses valid from T+1.
REQ-018 ISSUE (one cycle): lut_req=1, addresses = snapshot of voice v; then WAIT.
REQ-019 WAIT: hold addresses, count LUT_LATENCY-1 cycles (zero when LUT_LATENCY=1), then CAPTURE.
REQ-020 CAPTURE: lut_data sampled into res_data[v] at end of cycle A+LUT_LATENCY, A = that voice's ISSUE cycle; result visible A+LUT_LATENCY+1.
REQ-021 After CAPTURE, v<NUM_VOICES-1: v+1, next ISSUE in following cycle; slot length = LUT_LATENCY+1 cycles.
REQ-022 After CAPTURE of last voice: return to IDLE, done=1 for exactly the cycle last result first visible.
REQ-023 busy SHALL be 1 from T+1 through final CAPTURE cycle, 0 otherwise; total = NUM_VOICES x (LUT_LATENCY+1).
REQ-024 Snapshot isolates sequence: acc_*_in changes after cycle T SHALL not affect the current sequence.
REQ-025 ce_1m while busy: ignored, sequence continues unchanged, overrun set to 1 next cycle, held until reset.
REQ-026 ce_1m in the done cycle (IDLE): accepted as new start.
REQ-027 lut_acc_ps/lut_acc_t SHALL hold last value in IDLE; lut_req=0 in IDLE, WAIT, CAPTURE.
REQ-028 res_data[k] SHALL change only in voice k's CAPTURE; otherwise hold.

Reset
REQ-029 reset SHALL force IDLE, v=0, counters 0, lut_acc_ps=0, lut_acc_t=0, lut_req=0, res_data=0, busy=0, done=0, overrun=0.
REQ-030 reset mid-sequence SHALL abort without capturing; ce_1m coincident with reset SHALL be ignored.

Structure
REQ-031 sid_pkg SHALL hold NUM_VOICES default, 12-bit index width constant, and packed struct wave_lut_t {st, pt, ps, pst : 8 bits}.
REQ-032 Single module, no sub-module; FSM and slot counter inline.

Verification
REQ-033 L=3, ce_1m at T, acc_ps_in={0x123,0x456,0x789} -> lut_req at T+1,T+5,T+9; lut_acc_ps 0x123/0x456/0x789; done at T+13; busy T+1..T+12.
REQ-034 Model table returns data=address[7:0]-derived pattern with latency 3 -> res_data[k] matches voice k index, each visible one cycle after capture.
REQ-035 Second ce_1m at T+6 -> sequence unaffected, overrun=1 from T+7, stays 1 until reset.
REQ-036 Change acc_t_in[2] to 0xFFF at T+3 -> voice 2 lookup still uses value sampled at T.
REQ-037 reset at T+7 -> all outputs 0 at T+8, no done pulse, res_data[1] not written.
REQ-038 LUT_LATENCY=1, ce_1m again in done cycle -> busy 6 cycles, done at T+7, restart lut_req at T+8.
